// File: rtl/rl_ram_bist_pkg.sv
// Shared types and helpers for the rl_ram_1r1w_bist March C- engine.
// RL_RAM_BIST_CHECKERBOARD_EN selects the checkerboard data background;
// without it the background is all zeros.
package rl_ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_R0W1_UP,
        ST_R1W0_UP,
        ST_R0W1_DN,
        ST_R1W0_DN,
        ST_R0_DN,
        ST_DONE
    } bist_state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_e;

    typedef enum logic {
        PH_RD,
        PH_WR
    } phase_e;

    // Widest data word the background helper can produce.
    localparam int unsigned BG_MAX_W = 256;

`ifdef RL_RAM_BIST_CHECKERBOARD_EN
    localparam bit BG_CHECKER = 1'b1;
`else
    localparam bit BG_CHECKER = 1'b0;
`endif

    // Background "0" for a word: only the address parity matters, so the
    // caller passes addr[0]. Bits at or above width are zero.
    function automatic logic [BG_MAX_W-1:0] bg(input logic addr, input int unsigned width);
        logic [BG_MAX_W-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < BG_MAX_W; i++) begin
            if (i < width) begin
                pat[i] = BG_CHECKER & (((i % 2) == 0) ^ addr);
            end
        end
        return pat;
    endfunction

    // Address direction of a March element.
    function automatic dir_e dir_of(input bist_state_e st);
        dir_e d;
        case (st)
            ST_R0W1_DN, ST_R1W0_DN, ST_R0_DN: d = DIR_DN;
            default:                          d = DIR_UP;
        endcase
        return d;
    endfunction

    // Element that follows st in the March C- order.
    function automatic bist_state_e elem_next(input bist_state_e st);
        bist_state_e n;
        case (st)
            ST_W0:      n = ST_R0W1_UP;
            ST_R0W1_UP: n = ST_R1W0_UP;
            ST_R1W0_UP: n = ST_R0W1_DN;
            ST_R0W1_DN: n = ST_R1W0_DN;
            ST_R1W0_DN: n = ST_R0_DN;
            ST_R0_DN:   n = ST_DONE;
            default:    n = ST_IDLE;
        endcase
        return n;
    endfunction

    // Elements whose read expects the complemented background.
    function automatic logic expects_one(input bist_state_e st);
        return (st == ST_R1W0_UP) || (st == ST_R1W0_DN);
    endfunction

endpackage

// File: rtl/rl_ram_1r1w_bist_if.sv
// RAM-side port bundle between the BIST engine and a 1R1W RAM wrapper.
// Signal suffixes are from the BIST engine's point of view.
interface rl_ram_1r1w_bist_if #(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32
);
    localparam int unsigned BEBITS = (DBITS + 7) / 8;

    logic [ABITS-1:0]  ram_waddr_o;
    logic [DBITS-1:0]  ram_din_o;
    logic              ram_we_o;
    logic [BEBITS-1:0] ram_be_o;
    logic [ABITS-1:0]  ram_raddr_o;
    logic              ram_re_o;
    logic [DBITS-1:0]  ram_dout_i;

    modport master (
        output ram_waddr_o,
        output ram_din_o,
        output ram_we_o,
        output ram_be_o,
        output ram_raddr_o,
        output ram_re_o,
        input  ram_dout_i
    );

    modport slave (
        input  ram_waddr_o,
        input  ram_din_o,
        input  ram_we_o,
        input  ram_be_o,
        input  ram_raddr_o,
        input  ram_re_o,
        output ram_dout_i
    );
endinterface

// File: rtl/rl_ram_bist_agen.sv
// Up/down address counter with parallel load and terminal-count flag.
module rl_ram_bist_agen
    import rl_ram_bist_pkg::*;
#(
    parameter int unsigned ABITS = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [ABITS-1:0] load_val_i,
    input  logic             step_i,
    input  dir_e             dir_i,
    output logic [ABITS-1:0] cnt_o,
    output logic             tc_o
);
    logic [ABITS-1:0] cnt_q;
    logic [ABITS-1:0] cnt_d;

    // Load has priority over stepping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (step_i) begin
            if (dir_i == DIR_UP) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (dir_i == DIR_UP) ? (cnt_q == '1) : (cnt_q == '0);
endmodule

// File: rtl/rl_ram_1r1w_bist.sv
// March C- self-test initiator for a 1R1W RAM wrapper.
// Define RL_RAM_BIST_CHECKERBOARD_EN for a checkerboard data background.
module rl_ram_1r1w_bist
    import rl_ram_bist_pkg::*;
#(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic [ABITS-1:0]          fail_addr_o,
    output logic [DBITS-1:0]          fail_data_o,
    rl_ram_1r1w_bist_if.master        ram
);
    localparam int unsigned BEBITS = (DBITS + 7) / 8;

    bist_state_e      state_q, state_d;
    phase_e           phase_q, phase_d;
    logic             pass_q, pass_d;
    logic [ABITS-1:0] fail_addr_q, fail_addr_d;
    logic [DBITS-1:0] fail_data_q, fail_data_d;
    logic [ABITS-1:0] waddr_q, waddr_d;
    logic [DBITS-1:0] din_q, din_d;
    logic [ABITS-1:0] raddr_q, raddr_d;

    logic             we;
    logic             re;
    logic [DBITS-1:0] wdata;
    logic             cmp_en;
    logic [DBITS-1:0] exp_w;
    logic [DBITS-1:0] syndrome;

    logic [BG_MAX_W-1:0] bg_full;
    logic [DBITS-1:0]    bg_w;
    logic                unused_bg_hi;

    logic             cnt_load;
    logic [ABITS-1:0] cnt_load_val;
    logic             cnt_step;
    logic [ABITS-1:0] cnt;
    logic             cnt_tc;
    bist_state_e      nxt_elem;

    rl_ram_bist_agen #(
        .ABITS(ABITS)
    ) u_agen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .step_i     (cnt_step),
        .dir_i      (dir_of(state_q)),
        .cnt_o      (cnt),
        .tc_o       (cnt_tc)
    );

    assign bg_full      = bg(cnt[0], DBITS);
    assign bg_w         = bg_full[DBITS-1:0];
    assign unused_bg_hi = ^bg_full[BG_MAX_W-1:DBITS];
    assign nxt_elem     = elem_next(state_q);
    assign syndrome     = exp_w ^ ram.ram_dout_i;

    // March sequencing: per-state RAM commands, compare and element hand-off.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_step     = 1'b0;
        we           = 1'b0;
        re           = 1'b0;
        wdata        = '0;
        cmp_en       = 1'b0;
        exp_w        = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_W0;
                    phase_d      = PH_RD;
                    pass_d       = 1'b1;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                end
            end

            ST_W0: begin
                we    = 1'b1;
                wdata = bg_w;
                if (cnt_tc) begin
                    state_d      = nxt_elem;
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                end else begin
                    cnt_step = 1'b1;
                end
            end

            ST_R0W1_UP, ST_R1W0_UP, ST_R0W1_DN, ST_R1W0_DN, ST_R0_DN: begin
                if (phase_q == PH_RD) begin
                    re      = 1'b1;
                    phase_d = PH_WR;
                end else begin
                    cmp_en  = 1'b1;
                    exp_w   = expects_one(state_q) ? ~bg_w : bg_w;
                    phase_d = PH_RD;
                    if (state_q != ST_R0_DN) begin
                        we    = 1'b1;
                        wdata = ~exp_w;
                    end
                    if (cnt_tc) begin
                        state_d  = nxt_elem;
                        cnt_load = 1'b1;
                        if (dir_of(nxt_elem) == DIR_UP) begin
                            cnt_load_val = '0;
                        end else begin
                            cnt_load_val = '1;
                        end
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only the first mismatch of a run is recorded; pass_q doubles as
        // the "nothing recorded yet" flag.
        if (cmp_en && pass_q && (syndrome != '0)) begin
            pass_d      = 1'b0;
            fail_addr_d = cnt;
            fail_data_d = syndrome;
        end
    end

    // RAM address/data outputs follow the counter while in use, else hold.
    always_comb begin
        waddr_d = we ? cnt : waddr_q;
        din_d   = we ? wdata : din_q;
        raddr_d = re ? cnt : raddr_q;
    end

    // State, result and held-output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_RD;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            waddr_q     <= '0;
            din_q       <= '0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            waddr_q     <= waddr_d;
            din_q       <= din_d;
            raddr_q     <= raddr_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign pass_o      = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

    assign ram.ram_waddr_o = waddr_d;
    assign ram.ram_din_o   = din_d;
    assign ram.ram_we_o    = we;
    assign ram.ram_be_o    = {BEBITS{we}};
    assign ram.ram_raddr_o = raddr_d;
    assign ram.ram_re_o    = re;
endmodule

// File: doc/rl_ram_1r1w_bist.md
# rl_ram_1r1w_bist

Built-in self-test initiator for the 1R1W RAM wrappers in this library. It drives the write port (address, data, write enable, byte enables) and the read port (address, read enable) of one RAM instance, and checks the read data. It runs a March C- sequence over the full address space and reports pass/fail with the first failing address and bit syndrome. It sits between the test controller and a RAM wrapper; the parent muxes its RAM-side outputs with the functional path.

## Interface
- ABITS, 10, RAM address bits; N = 2**ABITS words
- DBITS, 32, RAM data bits; byte-enable width is (DBITS+7)/8
- clk_i  input  1  clock; rising edge
- rst_i  input  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- start_i  input  1  start pulse; sampled in IDLE only
- busy_o  output  1  test in progress
- done_o  output  1  one-cycle pulse on completion
- pass_o  output  1  result; valid from done_o until next start
- fail_addr_o  output  ABITS  address of first mismatch
- fail_data_o  output  DBITS  expected XOR read data at first mismatch
- ram_waddr_o  output  ABITS  RAM write address
- ram_din_o  output  DBITS  RAM write data
- ram_we_o  output  1  RAM write enable
- ram_be_o  output  (DBITS+7)/8  RAM byte enables; all ones
- ram_raddr_o  output  ABITS  RAM read address
- ram_re_o  output  1  RAM read enable
- ram_dout_i  input  DBITS  RAM read data; valid the cycle after ram_re_o

## Operation
- FSM states: IDLE, W0, R0W1_UP, R1W0_UP, R0W1_DN, R1W0_DN, R0_DN, DONE.
- start_i=1 in IDLE: the FSM enters W0 and sets pass_o=1. fail_addr_o and fail_data_o are cleared to 0. start_i outside IDLE is ignored.
- Data background bg(a): all zeros by default (see Configuration). "0" = bg(a); "1" = ~bg(a).
- W0: one cycle per address, addresses 0 to N-1. In each cycle: ram_we_o=1, ram_din_o="0".
- RW elements (R0W1_UP, R1W0_UP, R0W1_DN, R1W0_DN): two cycles per address, tracked by a phase bit.
  - Phase RD: ram_re_o=1, ram_raddr_o=a.
  - Phase WR: compare ram_dout_i against the expected value, and write the complementary value to a.
- UP elements run addresses 0 to N-1. DN elements run N-1 to 0.
- An element ends at its terminal address: N-1 for UP, 0 for DN. The counter then reloads for the next element, with no idle cycle between elements.
- R0_DN: two cycles per address (read, then compare); no write.
- DONE: held for exactly one cycle. In that cycle done_o=1; the FSM then returns to IDLE.
- Mismatch on the first failure only:
  - fail_addr_o = a
  - fail_data_o = expected XOR ram_dout_i
  - pass_o = 0
- Later mismatches do not update the fail registers. The test always runs to completion.
- ram_we_o and ram_re_o are never both 1 in the same cycle. Unused address and data outputs hold their last value.

## Timing
- Reset values: all outputs 0, state IDLE.
- rst_i mid-test: the next cycle is IDLE with all outputs 0; the RAM contents are undefined.
- start_i sampled at edge k: busy_o=1 from cycle k+1, and the first W0 write is issued in cycle k+1.
- Cycle counts:
  - W0: N cycles
  - each RW element: 2N cycles
  - R0_DN: 2N cycles
- busy_o is high for exactly 11N cycles. done_o pulses in the cycle after the last R0_DN compare, with busy_o=0 in that cycle.
- Read latency is fixed at 1 cycle. No output register is used on the RAM.

## Configuration
- Macro: RL_RAM_BIST_CHECKERBOARD_EN.
- Defined: bg(a) = alternating 0101… pattern (LSB=1), truncated to DBITS, XOR {DBITS{a[0]}}. Adjacent words therefore hold complementary patterns.
- Undefined: bg(a) = all zeros, so "0"=all-0 and "1"=all-1.
- Cycle counts and FSM are identical in both cases.

## Structure
- Package rl_ram_bist_pkg holds:
  - the state enum
  - a direction enum (UP/DN)
  - a function bg(addr, width) returning the background pattern, with the macro selecting its body
- Sub-module rl_ram_bist_agen: an ABITS-wide up/down address counter with load and a terminal-count flag, instantiated once.

## Test plan
All scenarios use ABITS=4, DBITS=8, N=16, macro undefined, and an ideal RAM model unless stated.
- Clean run: start_i pulse → busy_o high for 176 cycles, then done_o=1 for one cycle, pass_o=1, fail_addr_o=0, fail_data_o=0.
- Port check: the first 16 busy cycles have ram_we_o=1, ram_waddr_o=0..15, ram_din_o=0x00, ram_be_o=1'b1. In the whole run, ram_we_o & ram_re_o is never 1.
- Stuck-at fault (addr 5, bit 3 stuck at 1) → pass_o=0, fail_addr_o=5, fail_data_o=0x08. The first detection is in R0W1_UP.
- Reset mid-test: rst_i at busy cycle 50 → the next cycle has all outputs 0. A new start_i then gives a full 176-cycle run.
- start_i during busy: asserted at busy cycle 20 → ignored; done_o still occurs after 176 cycles.
- Macro defined, clean run: the W0 writes alternate 0x55 (even addresses) and 0xAA (odd addresses); pass_o=1.
